stopwatch_counter: RTL
======================

// Module: stopwatch_counter
// PURPOSE
// - Timebase and BCD time register driven by the stopwatch control FSM's enable/up_down outputs.
// - Counts SS.cc (00.00..59.99, centisecond resolution): up for elapsed time, down for countdown.
// - Digits feed the 7-segment display mux directly.
// PARAMETERS
// - TICK_DIV  1_000_000  clk cycles per centisecond tick (100 MHz -> 100 Hz); legal range >= 2
// PORTS
// - clk       in   1   system clock; all state updates on posedge
// - rst       in   1   reset, synchronous, active-high
// - clr       in   1   synchronous clear: digits, prescaler -> 0
// - enable    in   1   1 = prescaler runs and ticks are applied; 0 = pause, all state held
// - up_down   in   1   1 = count up, 0 = count down; sampled on tick cycles
// - load      in   1   synchronous load of load_val; prescaler -> 0
// - load_val  in   16  packed BCD {s_tens, s_ones, cs_tens, cs_ones}
// - digits    out  16  packed BCD, same layout as load_val; registered
// - tick_out  out  1   1-cycle pulse on every applied tick
// - rollover  out  1   1-cycle pulse when counting up wraps 59.99 -> 00.00
// - at_zero   out  1   level; registered; 1 when digits == 16'h0000
// BEHAVIOUR
// - Reset values: digits=0, prescaler=0, tick_out=0, rollover=0, at_zero=1.
// - Priority per cycle: rst > clr > load > tick. clr and load also zero the prescaler and suppress that cycle's tick, tick_out and rollover.
// - Prescaler: 0..TICK_DIV-1; increments only while enable=1; wraps to 0 when it equals TICK_DIV-1. That cycle is the tick cycle.
// - enable=0 holds the prescaler value (pause keeps phase); it does not clear it.
// - On a tick cycle, the digits update at the same clock edge; tick_out is 1 in the following cycle.
// - Latency: from reset, enable=1 continuously gives the first increment TICK_DIV clocks later.
// - Up count: cs_ones 9->0 carries into cs_tens; cs_tens 9->0 carries into s_ones; s_ones 9->0 carries into s_tens.
// - Up count wrap: s_tens 5->0 wraps the whole value 59.99 -> 00.00; rollover pulses in the cycle after the wrap edge.
// - Down count: mirror borrows (0->9, s_tens 0->5 never reached).
// - Down count at 00.00 saturates: the tick is consumed (prescaler wraps, tick_out=1), digits stay 0, no rollover, no underflow.
// - up_down may change at any time; the next tick uses the new direction, and prescaler phase is preserved.
// - Load sanitising: any nibble > 9 loads as 9; s_tens > 5 loads as 5.
// - at_zero is recomputed from the next digits value, so it is valid in the same cycle as digits.
// - rst or clr mid-count: outputs take reset values on the next edge, regardless of enable.
// STRUCTURE
// - Package stopwatch_pkg:
//   - typedef logic [3:0] bcd_t
//   - typedef struct packed {bcd_t s_tens, s_ones, cs_tens, cs_ones} sw_time_t
//   - localparams BCD_MAX=9, STENS_MAX=5
// - Sub-module bcd_digit, instantiated 4x:
//   - params MAX
//   - inputs inc, dec, clr, load, ld_val
//   - outputs q, carry (q==MAX & inc), borrow (q==0 & dec)
//   - carries/borrows are chained combinationally.
// - Top holds the prescaler, the saturation check (all zero & down -> suppress dec), pulse registers and at_zero.
// TESTING (TICK_DIV=4)
// - rst, then enable=1, up_down=1: digits=16'h0000 for 4 clks, then 16'h0001; after 40 clks 16'h0010.
// - load 16'h5998, up: tick1 -> 16'h5999; tick2 -> 16'h0000 with rollover=1 for exactly 1 cycle, at_zero=1.
// - load 16'h0100, up_down=0: tick -> 16'h0099, next tick -> 16'h0098; no rollover.
// - load 16'h0001, down: tick -> 16'h0000, at_zero=1.
//   Next 3 ticks: tick_out pulses, digits hold 0, rollover stays 0.
// - pause: up, enable=1 for 2 clks, enable=0 for 10 clks, enable=1 -> 16'h0001 after 2 more clks.
// - load_val=16'hAF7C -> digits=16'h5979.
//   clr+load on a tick cycle -> 16'h0000, tick_out=0.
//   rst mid-count -> all reset values next cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch BCD time register.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t s_tens;
    bcd_t s_ones;
    bcd_t cs_tens;
    bcd_t cs_ones;
  } sw_time_t;

  localparam bcd_t BCD_MAX   = 4'd9;
  localparam bcd_t STENS_MAX = 4'd5;

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// Single BCD digit counting 0..MAX with combinational carry/borrow for chaining.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = BCD_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  input  logic load,
  input  bcd_t ld_val,
  output bcd_t q,
  output logic carry,
  output logic borrow
);

  bcd_t q_q, q_d;

  assign q      = q_q;
  assign carry  = (q_q == MAX) && inc;
  assign borrow = (q_q == 4'd0) && dec;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      // Out-of-range load values clamp to the digit maximum
      q_d = (ld_val > MAX) ? MAX : ld_val;
    end else if (inc) begin
      q_d = (q_q == MAX) ? 4'd0 : q_q + 4'd1;
    end else if (dec) begin
      q_d = (q_q == 4'd0) ? MAX : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Centisecond prescaler plus SS.cc BCD up/down time register with tick/rollover pulses.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        enable,
  input  logic        up_down,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] digits,
  output logic        tick_out,
  output logic        rollover,
  output logic        at_zero
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic          tick_q, rollover_q, at_zero_q;
  logic          at_zero_d;
  logic          all_zero;
  sw_time_t      cur, ld;
  logic [3:0]    inc, dec, carry, borrow;

  assign ld = sw_time_t'(load_val);

  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (clr || load) begin
      presc_d = '0;
    end else if (enable) begin
      if (presc_q == PW'(TICK_DIV - 1)) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  assign all_zero = (cur == '0);

  // Down count saturates at 00.00: the tick is still reported but no borrow chain starts
  assign inc = {carry[2:0], tick && up_down};
  assign dec = {borrow[2:0], tick && !up_down && !all_zero};

  bcd_digit #(.MAX(BCD_MAX)) u_cs_ones (
    .clk(clk), .rst(rst), .inc(inc[0]), .dec(dec[0]), .clr(clr), .load(load),
    .ld_val(ld.cs_ones), .q(cur.cs_ones), .carry(carry[0]), .borrow(borrow[0])
  );

  bcd_digit #(.MAX(BCD_MAX)) u_cs_tens (
    .clk(clk), .rst(rst), .inc(inc[1]), .dec(dec[1]), .clr(clr), .load(load),
    .ld_val(ld.cs_tens), .q(cur.cs_tens), .carry(carry[1]), .borrow(borrow[1])
  );

  bcd_digit #(.MAX(BCD_MAX)) u_s_ones (
    .clk(clk), .rst(rst), .inc(inc[2]), .dec(dec[2]), .clr(clr), .load(load),
    .ld_val(ld.s_ones), .q(cur.s_ones), .carry(carry[2]), .borrow(borrow[2])
  );

  bcd_digit #(.MAX(STENS_MAX)) u_s_tens (
    .clk(clk), .rst(rst), .inc(inc[3]), .dec(dec[3]), .clr(clr), .load(load),
    .ld_val(ld.s_tens), .q(cur.s_tens), .carry(carry[3]), .borrow(borrow[3])
  );

  // Predict whether the digits will be zero after this edge
  always_comb begin
    at_zero_d = all_zero;
    if (clr) begin
      at_zero_d = 1'b1;
    end else if (load) begin
      at_zero_d = (load_val == 16'h0000);
    end else if (inc[0]) begin
      at_zero_d = carry[3];
    end else if (tick && !up_down) begin
      at_zero_d = all_zero || (cur == sw_time_t'(16'h0001));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      tick_q     <= 1'b0;
      rollover_q <= 1'b0;
      at_zero_q  <= 1'b1;
    end else begin
      presc_q    <= presc_d;
      tick_q     <= tick;
      rollover_q <= carry[3];
      at_zero_q  <= at_zero_d;
    end
  end

  assign digits   = cur;
  assign tick_out = tick_q;
  assign rollover = rollover_q;
  assign at_zero  = at_zero_q;

endmodule
